// File: rtl/fb_scanout.sv
// fb_scanout: character-cell framebuffer scan-out engine.
//
// The visible raster is split into cells of CELL_W x CELL_H pixels. Each cell
// maps to one 4-bit colour index in an external single-port synchronous RAM
// holding FB_ROWS x FB_COLS entries, addressed as {row, col}. During visible
// pixels the RAM port is used for reads. During blanking the host may write
// through it.
//
// Ports:
//   clk, rst                  - pixel clock, synchronous active-high reset
//   hsync_in, vsync_in        - syncs from the timing generator
//   active_in                 - visible-pixel flag from the timing generator
//   wr_req, wr_addr, wr_data  - host write request. Held until wr_ack.
//   wr_ack                    - one-cycle write-accepted pulse
//   ram_addr, ram_din, ram_we - registered RAM port controls
//   ram_dout                  - RAM read data, one cycle after ram_addr
//   pixel_out                 - registered colour index. Zero when blank.
//   hsync_out, vsync_out,
//   active_out                - timing inputs delayed by two registers
module fb_scanout #(
  parameter int FB_COLS         = 32,
  parameter int FB_ROWS         = 32,
  parameter int CELL_W          = 20,
  parameter int CELL_H          = 15,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  localparam int COL_W          = $clog2(FB_COLS),
  localparam int ROW_W          = $clog2(FB_ROWS),
  localparam int ADDR_WIDTH     = COL_W + ROW_W,
  localparam int DATA_WIDTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  active_in,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [DATA_WIDTH-1:0] pixel_out,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic                  active_out
);

  localparam int   CX_W     = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int   CY_W     = (CELL_H > 1) ? $clog2(CELL_H) : 1;
  localparam logic SYNC_ON  = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic SYNC_OFF = ~SYNC_ON;

  logic [CX_W-1:0]       cell_x_q, cell_x_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [CY_W-1:0]       cell_y_q, cell_y_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic                  active_prev_q;
  logic                  vsync_prev_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
  logic                  ram_we_q, ram_we_d;
  logic                  wr_ack_q, wr_ack_d;
  logic [DATA_WIDTH-1:0] pixel_q;
  // Delay stages packed as {hsync, vsync, active}.
  logic [2:0]            tim_s1_q, tim_s2_q;

  logic vs_start;
  logic line_end;

  assign vs_start = (vsync_in == SYNC_ON) && (vsync_prev_q != SYNC_ON);
  assign line_end = active_prev_q && !active_in;

  // Cell/row position counters. A frame start overrides everything else.
  always_comb begin
    cell_x_d = cell_x_q;
    col_d    = col_q;
    cell_y_d = cell_y_q;
    row_d    = row_q;
    if (vs_start) begin
      cell_x_d = '0;
      col_d    = '0;
      cell_y_d = '0;
      row_d    = '0;
    end else if (active_in) begin
      if (cell_x_q == CX_W'(CELL_W - 1)) begin
        cell_x_d = '0;
        // Pixels past the last column keep reading the last column.
        if (col_q != COL_W'(FB_COLS - 1)) col_d = col_q + 1'b1;
      end else begin
        cell_x_d = cell_x_q + 1'b1;
      end
    end else if (line_end) begin
      cell_x_d = '0;
      col_d    = '0;
      if (cell_y_q == CY_W'(CELL_H - 1)) begin
        cell_y_d = '0;
        if (row_q != ROW_W'(FB_ROWS - 1)) row_d = row_q + 1'b1;
      end else begin
        cell_y_d = cell_y_q + 1'b1;
      end
    end
  end

  // RAM port arbitration. Visible pixels always own the port. The host only
  // gets it during blanking, and is acknowledged in the cycle its write issues.
  always_comb begin
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_we_d   = 1'b0;
    wr_ack_d   = 1'b0;
    if (active_in) begin
      ram_addr_d = {row_q, col_q};
    end else if (wr_req) begin
      ram_addr_d = wr_addr;
      ram_din_d  = wr_data;
      ram_we_d   = 1'b1;
      wr_ack_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cell_x_q      <= '0;
      col_q         <= '0;
      cell_y_q      <= '0;
      row_q         <= '0;
      active_prev_q <= 1'b0;
      vsync_prev_q  <= SYNC_OFF;
      ram_addr_q    <= '0;
      ram_din_q     <= '0;
      ram_we_q      <= 1'b0;
      wr_ack_q      <= 1'b0;
      pixel_q       <= '0;
      tim_s1_q      <= {SYNC_OFF, SYNC_OFF, 1'b0};
      tim_s2_q      <= {SYNC_OFF, SYNC_OFF, 1'b0};
    end else begin
      cell_x_q      <= cell_x_d;
      col_q         <= col_d;
      cell_y_q      <= cell_y_d;
      row_q         <= row_d;
      active_prev_q <= active_in;
      vsync_prev_q  <= vsync_in;
      ram_addr_q    <= ram_addr_d;
      ram_din_q     <= ram_din_d;
      ram_we_q      <= ram_we_d;
      wr_ack_q      <= wr_ack_d;
      tim_s1_q      <= {hsync_in, vsync_in, active_in};
      tim_s2_q      <= tim_s1_q;
      // Stage 1 lines up with ram_addr and stage 2 lines up with ram_dout.
      // The stage-2 active bit therefore qualifies the data returned.
      pixel_q       <= tim_s2_q[0] ? ram_dout : '0;
    end
  end

  assign ram_addr   = ram_addr_q;
  assign ram_din    = ram_din_q;
  assign ram_we     = ram_we_q;
  assign wr_ack     = wr_ack_q;
  assign pixel_out  = pixel_q;
  assign hsync_out  = tim_s2_q[2];
  assign vsync_out  = tim_s2_q[1];
  assign active_out = tim_s2_q[0];

endmodule

// File: tb/tb_fb_scanout.sv
// Testbench for fb_scanout. It provides a behavioural RAM. A pixel/line-count
// model predicts every output each cycle. Directed scenarios add hand-computed
// expectations.
module tb_fb_scanout;
  localparam int   AW       = 10;
  localparam logic SYNC_ON  = 1'b0;
  localparam logic SYNC_OFF = 1'b1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hsync_in = SYNC_OFF, vsync_in = SYNC_OFF, active_in = 1'b0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [3:0]    wr_data = '0;
  logic          wr_ack, ram_we, hsync_out, vsync_out, active_out;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_din, pixel_out;
  logic [3:0]    ram_dout = '0;
  logic [3:0]    ram_mem [0:1023];

  int n_cmp = 0;
  int n_err = 0;

  fb_scanout dut (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .active_in(active_in), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .pixel_out(pixel_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .active_out(active_out)
  );

  always #5 clk = ~clk;

  // External synchronous single-port RAM (read-before-write).
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic       act;
    logic [3:0] data;
    logic       hs;
    logic       vs;
  } hist_t;

  hist_t      hist[$];
  logic [3:0] shadow [0:1023];
  int         m_x, m_y;
  logic       m_pa, m_pvs, m_we, m_ack;
  logic [AW-1:0] m_addr;
  logic [3:0] m_din, e_pix;
  logic       e_act, e_hs, e_vs;

  // Screen position -> framebuffer address: 20x15 pixel cells, clamped to 32x32.
  function automatic logic [AW-1:0] cell_addr(input int x, input int y);
    int c, r;
    c = x / 20; if (c > 31) c = 31;
    r = y / 15; if (r > 31) r = 31;
    return AW'(r * 32 + c);
  endfunction

  initial begin
    hist_t h;
    hist_t rh;
    logic  vs_start;
    rh = '{act: 1'b0, data: 4'h0, hs: SYNC_OFF, vs: SYNC_OFF};
    for (int i = 0; i < 3; i++) hist.push_front(rh);
    forever begin
      @(posedge clk);
      if (rst) begin
        m_x = 0; m_y = 0; m_pa = 1'b0; m_pvs = SYNC_OFF;
        m_addr = '0; m_din = '0; m_we = 1'b0; m_ack = 1'b0;
        hist.push_front(rh); void'(hist.pop_back());
        e_act = 1'b0; e_hs = SYNC_OFF; e_vs = SYNC_OFF; e_pix = 4'h0;
      end else begin
        vs_start = (vsync_in == SYNC_ON) && (m_pvs != SYNC_ON);
        h.act  = active_in;
        h.data = active_in ? shadow[cell_addr(m_x, m_y)] : 4'h0;
        h.hs   = hsync_in;
        h.vs   = vsync_in;
        if (active_in) begin
          m_addr = cell_addr(m_x, m_y); m_we = 1'b0; m_ack = 1'b0;
        end else if (wr_req) begin
          m_addr = wr_addr; m_din = wr_data; m_we = 1'b1; m_ack = 1'b1;
          shadow[wr_addr] = wr_data;
        end else begin
          m_we = 1'b0; m_ack = 1'b0;
        end
        if (vs_start) begin m_x = 0; m_y = 0; end
        else if (active_in) m_x++;
        else if (m_pa) begin m_x = 0; m_y++; end
        m_pa = active_in; m_pvs = vsync_in;
        hist.push_front(h); void'(hist.pop_back());
        e_act = hist[1].act; e_hs = hist[1].hs; e_vs = hist[1].vs;
        e_pix = hist[2].act ? hist[2].data : 4'h0;
      end
      #1;
      chk("ram_addr", ram_addr, m_addr);
      chk("ram_we", ram_we, m_we);
      chk("ram_din", ram_din, m_din);
      chk("wr_ack", wr_ack, m_ack);
      chk("pixel_out", pixel_out, e_pix);
      chk("active_out", active_out, e_act);
      chk("hsync_out", hsync_out, e_hs);
      chk("vsync_out", vsync_out, e_vs);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(); @(negedge clk); endtask

  task automatic blank(input int n);
    active_in = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic frame_start();
    active_in = 1'b0;
    vsync_in = SYNC_ON;  cyc(); cyc();
    vsync_in = SYNC_OFF; cyc(); cyc();
  endtask

  task automatic short_lines(input int n);
    for (int l = 0; l < n; l++) begin
      active_in = 1'b1; cyc();
      active_in = 1'b0; cyc();
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic [AW-1:0] wa [4];
    logic [3:0]    wd [4];
    int            acks;
    wa[0] = 10'd0;  wd[0] = 4'h5;
    wa[1] = 10'd1;  wd[1] = 4'h6;
    wa[2] = 10'd2;  wd[2] = 4'h7;
    wa[3] = 10'd32; wd[3] = 4'h9;
    for (int i = 0; i < 1024; i++) begin ram_mem[i] = 4'h0; shadow[i] = 4'h0; end

    // Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      rst = 1'b1;
      hsync_in = 1'($urandom); vsync_in = 1'($urandom); active_in = 1'($urandom);
      wr_req = 1'($urandom); wr_addr = AW'($urandom); wr_data = 4'($urandom);
      cyc();
      chk("rst_we", ram_we, 0);
      chk("rst_ack", wr_ack, 0);
    end
    chk("rst_addr", ram_addr, 0);
    chk("rst_pix", pixel_out, 0);
    chk("rst_vs", vsync_out, 1);
    chk("rst_hs", hsync_out, 1);
    chk("rst_act", active_out, 0);
    rst = 1'b0; hsync_in = SYNC_OFF; vsync_in = SYNC_OFF; active_in = 1'b0; wr_req = 1'b0;
    cyc(); cyc();

    // Back-to-back writes in one blanking interval.
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      wr_req = 1'b1; wr_addr = wa[k]; wr_data = wd[k];
      cyc();
      chk("b2b_ack", wr_ack, 1);
      chk("b2b_we", ram_we, 1);
      chk("b2b_addr", ram_addr, wa[k]);
      if (wr_ack) acks++;
    end
    wr_req = 1'b0;
    cyc();
    chk("b2b_count", acks, 4);
    chk("b2b_idle_ack", wr_ack, 0);
    chk("b2b_addr_hold", ram_addr, 32);

    // Latency and address sequence over 45 active pixels.
    frame_start();
    for (int i = 0; i < 45; i++) begin
      active_in = 1'b1; cyc();
      chk("lat_addr", ram_addr, i / 20);
      if (i == 0) chk("lat_actout0", active_out, 0);
      if (i == 1) chk("lat_actout1", active_out, 1);
      if (i == 1) chk("lat_pix1", pixel_out, 0);
      if (i == 2) chk("lat_pix2", pixel_out, 5);
      if (i == 22) chk("lat_pix22", pixel_out, 6);
      if (i == 42) chk("lat_pix42", pixel_out, 7);
    end
    active_in = 1'b0;
    for (int j = 0; j < 20; j++) begin
      hsync_in = (j >= 4 && j < 9) ? SYNC_ON : SYNC_OFF;
      cyc();
      if (j == 1) chk("tail_pix", pixel_out, 7);
      if (j == 2) chk("blank_pix", pixel_out, 0);
    end

    // Row advance after 15 lines, column saturation on a 700-pixel line.
    frame_start();
    for (int l = 0; l < 15; l++) begin
      for (int i = 0; i < 640; i++) begin active_in = 1'b1; cyc(); end
      blank(20);
    end
    for (int i = 0; i < 700; i++) begin
      active_in = 1'b1; cyc();
      if (i == 0) chk("row1_addr", ram_addr, 32);
      if (i == 2) chk("row1_pix", pixel_out, 9);
      if (i == 660) chk("colsat_addr", ram_addr, 63);
      if (i == 699) chk("colsat_end", ram_addr, 63);
    end
    blank(20);

    // Arbitration: a write raised mid-line waits for blanking.
    for (int i = 0; i < 50; i++) begin
      active_in = 1'b1;
      if (i == 10) begin wr_req = 1'b1; wr_addr = 10'h3FF; wr_data = 4'hA; end
      cyc();
      if (i >= 10) begin
        chk("arb_no_ack", wr_ack, 0);
        chk("arb_no_we", ram_we, 0);
      end
    end
    active_in = 1'b0; cyc();
    chk("arb_ack", wr_ack, 1);
    chk("arb_we", ram_we, 1);
    chk("arb_addr", ram_addr, 10'h3FF);
    chk("arb_din", ram_din, 4'hA);
    wr_req = 1'b0;
    blank(10);

    // Read back 0x3FF: row saturates at 31, then column 31.
    frame_start();
    short_lines(470);
    for (int i = 0; i < 700; i++) begin
      active_in = 1'b1; cyc();
      if (i == 620) chk("rb_addr", ram_addr, 10'h3FF);
      if (i == 622) chk("rb_pix", pixel_out, 4'hA);
    end
    blank(10);

    // Frame restart mid-line once row 5 is reached.
    frame_start();
    short_lines(80);
    for (int i = 0; i < 40; i++) begin
      active_in = 1'b1;
      vsync_in = (i == 30 || i == 31) ? SYNC_ON : SYNC_OFF;
      cyc();
      if (i == 30) chk("vs_pre_addr", ram_addr, 161);
      if (i == 31) chk("vs_restart_addr", ram_addr, 0);
      if (i == 32) chk("vs_next_addr", ram_addr, 0);
    end
    vsync_in = SYNC_OFF;
    blank(10);
    chk("vs_blank_pix", pixel_out, 0);

    // Reset mid-line with a pending write.
    for (int i = 0; i < 5; i++) begin active_in = 1'b1; cyc(); end
    rst = 1'b1; active_in = 1'b0; wr_req = 1'b1; wr_addr = 10'h155; wr_data = 4'h3;
    cyc();
    chk("midrst_ack", wr_ack, 0);
    chk("midrst_addr", ram_addr, 0);
    cyc();
    chk("midrst_we", ram_we, 0);
    rst = 1'b0; wr_req = 1'b0;
    blank(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
